// File: rtl/lighthouse_ootx_decoder.sv
// lighthouse_ootx_decoder
//   Bit-serial deframer for the Lighthouse v1 OOTX side channel. Hunts for the
//   preamble (>=17 zeros then a 1), strips the 1-valued stuff bit after every
//   16-bit word, and streams out the payload bytes. Reports the little-endian
//   length, frame completion and a CRC-32 check over the emitted bytes.
//
// Ports
//   clk          : single clock, posedge
//   reset        : asynchronous, active-low; clears all state and outputs
//   bit_strobe   : one-cycle qualifier, bit_in is valid (may be high every cycle)
//   bit_in       : OOTX data bit
//   frame_start  : pulse, preamble plus sync bit seen
//   length       : payload length of the current frame
//   byte_valid   : pulse, byte_data carries the next payload byte
//   byte_data    : payload byte, held until the next byte_valid
//   frame_done   : pulse, both CRC words received
//   crc_ok       : CRC compare result, valid with frame_done, held until next frame_start
//   frame_error  : pulse, framing abort (bad stuff bit, oversize length, resync)
//   state_dbg    : current FSM state (HUNT=0, LEN=1, PAYLOAD=2, CRC_LO=3, CRC_HI=4)
//
// Handshake: bit_strobe is a pure valid qualifier with no ready/backpressure;
// every strobed bit is consumed on the clock edge that samples it. All output
// pulses appear in the cycle after the strobe that caused them.

module lighthouse_ootx_decoder #(
  parameter int MAX_LEN = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_strobe,
  input  logic        bit_in,
  output logic        frame_start,
  output logic [15:0] length,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        frame_error,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CRC_LO, CRC_HI} state_t;

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [4:0]  ZRUN_SAT  = 5'd17;
  localparam logic [4:0]  STUFF_POS = 5'd16;

  // Reflected CRC-32, one byte folded in LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  zrun_q, zrun_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [15:0] shreg_q, shreg_d;
  logic [6:0]  byte_idx_q, byte_idx_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] crc_lo_q, crc_lo_d;
  logic [15:0] length_q, length_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic        crc_ok_q, crc_ok_d;
  logic        start_q, start_d;
  logic        bvalid_q, bvalid_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic [15:0] len_rx;
  logic [7:0]  low_byte;
  logic [31:0] crc_rx;

  // At the stuff bit the shift register holds the complete word.
  assign len_rx   = {shreg_q[7:0], shreg_q[15:8]};
  // Byte completed by the current bit (valid at data bits 7 and 15).
  assign low_byte = {shreg_q[6:0], bit_in};
  assign crc_rx   = {shreg_q[7:0], shreg_q[15:8], crc_lo_q[7:0], crc_lo_q[15:8]};

  always_comb begin
    state_d     = state_q;
    zrun_d      = zrun_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    byte_idx_d  = byte_idx_q;
    crc_d       = crc_q;
    crc_lo_d    = crc_lo_q;
    length_d    = length_q;
    byte_data_d = byte_data_q;
    crc_ok_d    = crc_ok_q;
    start_d     = 1'b0;
    bvalid_d    = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;

    if (bit_strobe) begin
      // Zero-run tracking runs in every state, including stuff slots.
      if (bit_in) zrun_d = 5'd0;
      else if (zrun_q != ZRUN_SAT) zrun_d = zrun_q + 5'd1;

      if (bit_in && zrun_q == ZRUN_SAT) begin
        // Preamble found; outside HUNT this aborts the frame in progress.
        start_d  = 1'b1;
        error_d  = (state_q != HUNT);
        state_d  = LEN;
        bitcnt_d = 5'd0;
        crc_d    = 32'hFFFF_FFFF;
        crc_ok_d = 1'b0;
      end else if (state_q != HUNT) begin
        if (bitcnt_q != STUFF_POS) begin
          shreg_d  = {shreg_q[14:0], bit_in};
          bitcnt_d = bitcnt_q + 5'd1;
          if (state_q == PAYLOAD && (bitcnt_q == 5'd7 || bitcnt_q == 5'd15)) begin
            byte_idx_d = byte_idx_q + 7'd1;
            // Odd lengths carry a pad byte that is neither emitted nor CRC'd.
            if ({9'd0, byte_idx_q} < length_q) begin
              bvalid_d    = 1'b1;
              byte_data_d = low_byte;
              crc_d       = crc32_byte(crc_q, low_byte);
            end
          end
        end else begin
          bitcnt_d = 5'd0;
          if (!bit_in) begin
            error_d = 1'b1;
            state_d = HUNT;
          end else begin
            case (state_q)
              LEN: begin
                if (len_rx > MAX_LEN_W) begin
                  error_d = 1'b1;
                  state_d = HUNT;
                end else begin
                  length_d   = len_rx;
                  byte_idx_d = 7'd0;
                  state_d    = (len_rx == 16'd0) ? CRC_LO : PAYLOAD;
                end
              end
              PAYLOAD: begin
                if ({9'd0, byte_idx_q} >= length_q) state_d = CRC_LO;
              end
              CRC_LO: begin
                crc_lo_d = shreg_q;
                state_d  = CRC_HI;
              end
              CRC_HI: begin
                done_d   = 1'b1;
                crc_ok_d = (~crc_q == crc_rx);
                state_d  = HUNT;
              end
              default: state_d = HUNT;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= HUNT;
      zrun_q      <= 5'd0;
      bitcnt_q    <= 5'd0;
      shreg_q     <= 16'd0;
      byte_idx_q  <= 7'd0;
      crc_q       <= 32'd0;
      crc_lo_q    <= 16'd0;
      length_q    <= 16'd0;
      byte_data_q <= 8'd0;
      crc_ok_q    <= 1'b0;
      start_q     <= 1'b0;
      bvalid_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      zrun_q      <= zrun_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      byte_idx_q  <= byte_idx_d;
      crc_q       <= crc_d;
      crc_lo_q    <= crc_lo_d;
      length_q    <= length_d;
      byte_data_q <= byte_data_d;
      crc_ok_q    <= crc_ok_d;
      start_q     <= start_d;
      bvalid_q    <= bvalid_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign frame_start = start_q;
  assign length      = length_q;
  assign byte_valid  = bvalid_q;
  assign byte_data   = byte_data_q;
  assign frame_done  = done_q;
  assign crc_ok      = crc_ok_q;
  assign frame_error = error_q;
  assign state_dbg   = state_q;

endmodule
